// File: rtl/shift_rot_unit.sv
// shift_rot_unit
// Multi-cycle shift/rotate execution unit for the V30MZ execute stage.
// Moves the operand one bit position per clock so the latency tracks the
// shift count, then presents the result and flag updates for one cycle.
//
// Ports
//   clock     : rising-edge clock
//   reset_n   : asynchronous active-low reset
//   start     : request, accepted only while idle
//   abort     : synchronous kill of the operation in flight
//   op        : 0 ROL, 1 ROR, 2 ROLC, 3 RORC, 4 SHL, 5 SHR, 6 SHRA, 7 = SHL
//   size      : 0 = low byte, 1 = full DATA_W operand
//   a         : operand (sampled on accept)
//   count     : shift count, low CNT_W bits used (sampled on accept)
//   cy_in     : carry-in for ROLC/RORC (sampled on accept)
//   busy      : high from the cycle after accept through the done cycle
//   done      : one-cycle completion pulse
//   result    : shifted value; in byte mode bits above 7 are a's upper bits
//   flags     : {Z, S, P, V, CY, AC}
//   flags_we  : per-flag write enable, zero whenever done is low
module shift_rot_unit #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 5
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [2:0]        op,
  input  logic              size,
  input  logic [DATA_W-1:0] a,
  input  logic [7:0]        count,
  input  logic              cy_in,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic [5:0]        flags,
  output logic [5:0]        flags_we
);

  localparam int MSB_W = $clog2(DATA_W);

  localparam logic [2:0] OP_ROL  = 3'd0;
  localparam logic [2:0] OP_ROR  = 3'd1;
  localparam logic [2:0] OP_ROLC = 3'd2;
  localparam logic [2:0] OP_RORC = 3'd3;
  localparam logic [2:0] OP_SHL  = 3'd4;
  localparam logic [2:0] OP_SHR  = 3'd5;
  localparam logic [2:0] OP_SHRA = 3'd6;
  localparam logic [2:0] OP_SHL7 = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_nx;
  logic [CNT_W-1:0]  n_q;
  logic [DATA_W-1:0] work_q;
  logic              cy_q;
  logic [2:0]        op_q;
  logic              size_q;
  logic              a_msb_q;

  logic              accept;
  logic              last_step;
  logic [CNT_W-1:0]  cnt_m;
  logic [DATA_W:0]   step_w;
  logic              cnt_hi_unused;

  // Index of the most significant bit of the active field.
  function automatic logic [MSB_W-1:0] field_msb(input logic sz);
    return sz ? MSB_W'(DATA_W-1) : MSB_W'(7);
  endfunction

  function automatic logic [DATA_W-1:0] field_mask(input logic sz);
    return sz ? {DATA_W{1'b1}} : DATA_W'(8'hFF);
  endfunction

  function automatic logic is_left(input logic [2:0] o);
    return (o == OP_ROL) || (o == OP_ROLC) || (o == OP_SHL) || (o == OP_SHL7);
  endfunction

  // One 1-bit move on the active field; bits outside the field pass through.
  // Returns {carry_out, new_value}. ROLC/RORC treat {CY, field} as one ring.
  function automatic logic [DATA_W:0] step_one(input logic [DATA_W-1:0] v,
                                               input logic              c,
                                               input logic [2:0]        o,
                                               input logic              sz);
    logic [MSB_W-1:0]  m;
    logic [DATA_W-1:0] fm;
    logic [DATA_W-1:0] f;
    logic [DATA_W-1:0] r;
    logic              bin;
    logic              bout;
    m  = field_msb(sz);
    fm = field_mask(sz);
    f  = v & fm;
    case (o)
      OP_ROL:           bin = v[m];
      OP_ROR:           bin = v[0];
      OP_ROLC, OP_RORC: bin = c;
      OP_SHRA:          bin = v[m];
      default:          bin = 1'b0;
    endcase
    if (is_left(o)) begin
      bout = v[m];
      r    = (f << 1) & fm;
      r[0] = bin;
    end else begin
      bout = v[0];
      r    = f >> 1;
      r[m] = bin;
    end
    return {bout, r | (v & ~fm)};
  endfunction

  // Flag vector {Z, S, P, V, CY, AC} for a finished non-zero-count operation.
  function automatic logic [5:0] calc_flags(input logic [DATA_W-1:0] r,
                                            input logic              c,
                                            input logic [2:0]        o,
                                            input logic              sz,
                                            input logic              amsb);
    logic [MSB_W-1:0]  m;
    logic [DATA_W-1:0] fm;
    logic              v;
    m  = field_msb(sz);
    fm = field_mask(sz);
    case (o)
      OP_ROR, OP_RORC: v = r[m] ^ r[m - MSB_W'(1)];
      OP_SHR:          v = amsb;
      OP_SHRA:         v = 1'b0;
      default:         v = r[m] ^ c;
    endcase
    return {((r & fm) == '0), r[m], ~^r[7:0], v, c, 1'b0};
  endfunction

  // Rotates only touch CY and V; shifts also update P, S and Z.
  function automatic logic [5:0] we_for(input logic [2:0] o);
    return (o <= OP_RORC) ? 6'b000110 : 6'b111110;
  endfunction

  assign cnt_m         = count[CNT_W-1:0];
  assign cnt_hi_unused = |(count >> CNT_W);
  assign accept        = (state_q == IDLE) && start && !abort;
  assign last_step     = (state_q == STEP) && (n_q == CNT_W'(1));
  assign step_w        = step_one(work_q, cy_q, op_q, size_q);

  // ---- sequencer state register ----
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nx;
    end
  end

  always_comb begin
    state_nx = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_nx = (cnt_m == '0) ? DONE : STEP;
        end
      end
      STEP: begin
        if (abort) begin
          state_nx = IDLE;
        end else if (n_q == CNT_W'(1)) begin
          state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // ---- working operand / carry (data only, no reset) ----
  always_ff @(posedge clock) begin
    if (accept) begin
      work_q  <= a;
      cy_q    <= cy_in;
      op_q    <= op;
      size_q  <= size;
      a_msb_q <= a[field_msb(size)];
    end else if (state_q == STEP) begin
      cy_q   <= step_w[DATA_W];
      work_q <= step_w[DATA_W-1:0];
    end
  end

  // ---- registered control and outputs ----
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      n_q      <= '0;
      result   <= '0;
      flags    <= '0;
      flags_we <= '0;
    end else begin
      busy <= (state_nx != IDLE);
      done <= (state_nx == DONE);

      if (accept) begin
        n_q <= cnt_m;
      end else if ((state_q == STEP) && !abort) begin
        n_q <= n_q - CNT_W'(1);
      end else if (abort) begin
        n_q <= '0;
      end

      if (abort && (state_q != IDLE)) begin
        result   <= '0;
        flags    <= '0;
        flags_we <= '0;
      end else if (accept && (cnt_m == '0)) begin
        result   <= a;
        flags    <= '0;
        flags_we <= '0;
      end else if (last_step) begin
        result   <= step_w[DATA_W-1:0];
        flags    <= calc_flags(step_w[DATA_W-1:0], step_w[DATA_W], op_q, size_q, a_msb_q);
        flags_we <= we_for(op_q);
      end else if (state_q == DONE) begin
        flags_we <= '0;
      end
    end
  end

endmodule
